// File: rtl/simd_top.sv
// 32-lane byte SIMD coprocessor on an 8080-style host bus, with camera/LCD byte routing.
// Optional RESULT_SAT_EN: accumulate saturates at all-ones, subtract clamps at zero.
module simd_top #(
  parameter int LANES  = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CS,
  input  logic              WR,
  input  logic              RD,
  input  logic              CD,
  input  logic              excute,
  input  logic              sel_poc,
  input  logic              sel_sod,
  input  logic              direction,
  inout  wire  [DATA_W-1:0] pico_data,
  input  logic [DATA_W-1:0] cam_data,
  output logic [DATA_W-1:0] LCD_data
);

  localparam int RES_W = 2 * DATA_W;
  localparam int PTR_W = $clog2(LANES) + 1;

  // [1:0] is the two-flop synchronizer, [2] the delayed copy for edge detection
  logic [2:0] wr_sh, rd_sh, ex_sh;
  logic       wr_rise, rd_fall, ex_rise;

  logic [6:0]        addr_reg;
  logic [1:0]        mode_reg, mode_eff;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_fire, data_wr, a_we, b_we, mode_we;

  logic [DATA_W-1:0] a_bank [LANES];
  logic [DATA_W-1:0] b_bank [LANES];
  logic [RES_W-1:0]  r_bank [LANES];
  logic [DATA_W-1:0] a_eff  [LANES];
  logic [DATA_W-1:0] b_eff  [LANES];
  logic [RES_W-1:0]  r_next [LANES];

  logic [RES_W-1:0]  rd_word;
  logic [DATA_W-1:0] rd_byte;

  assign wr_rise = wr_sh[1] & ~wr_sh[2];
  assign rd_fall = ~rd_sh[1] & rd_sh[2];
  assign ex_rise = ex_sh[1] & ~ex_sh[2];

  assign wr_data = sel_poc ? cam_data : pico_data;
  assign wr_fire = wr_rise & CS;
  assign data_wr = wr_fire & ~CD;
  assign a_we    = data_wr & (addr_reg[6:5] == 2'b00);
  assign b_we    = data_wr & (addr_reg[6:5] == 2'b01);
  assign mode_we = data_wr & (addr_reg == 7'd64);

  // A write landing in the same cycle as execute is forwarded into the compute
  assign mode_eff = mode_we ? wr_data[1:0] : mode_reg;

  function automatic logic [RES_W-1:0] lane_op(input logic [1:0] m,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [RES_W-1:0] r);
    logic [RES_W-1:0] prod;
    logic [RES_W:0]   acc;
    lane_op = '0;
    prod    = RES_W'(a) * RES_W'(b);
    acc     = {1'b0, prod} + {1'b0, r};
    case (m)
      2'd0: lane_op = RES_W'(a) + RES_W'(b);
`ifdef RESULT_SAT_EN
      2'd1: lane_op = acc[RES_W] ? {RES_W{1'b1}} : acc[RES_W-1:0];
      2'd2: lane_op = prod;
      default: lane_op = (a < b) ? '0 : RES_W'(a) - RES_W'(b);
`else
      2'd1: lane_op = acc[RES_W-1:0];
      2'd2: lane_op = prod;
      default: lane_op = RES_W'(a) - RES_W'(b);
`endif
    endcase
  endfunction

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign a_eff[gi]  = (a_we && addr_reg[4:0] == 5'(gi)) ? wr_data : a_bank[gi];
    assign b_eff[gi]  = (b_we && addr_reg[4:0] == 5'(gi)) ? wr_data : b_bank[gi];
    assign r_next[gi] = lane_op(mode_eff, a_eff[gi], b_eff[gi], r_bank[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sh <= '0;
      rd_sh <= '0;
      ex_sh <= '0;
    end else begin
      wr_sh <= {wr_sh[1:0], WR};
      rd_sh <= {rd_sh[1:0], RD};
      ex_sh <= {ex_sh[1:0], excute};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        a_bank[i] <= '0;
        b_bank[i] <= '0;
        r_bank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        a_bank[i] <= a_eff[i];
        b_bank[i] <= b_eff[i];
        if (ex_rise) r_bank[i] <= r_next[i];
      end
    end
  end

  // Data writes below 64 step the address, wrapping inside their own bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      mode_reg <= '0;
    end else begin
      if (wr_fire && CD)
        addr_reg <= pico_data[6:0];
      else if (data_wr && !addr_reg[6])
        addr_reg <= {addr_reg[6:5], addr_reg[4:0] + 5'd1};
      if (mode_we) mode_reg <= wr_data[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_ptr <= '0;
    else if (ex_rise)
      rd_ptr <= '0;
    else if (rd_fall && CS)
      rd_ptr <= rd_ptr + 1'b1;
  end

  assign rd_word = r_bank[rd_ptr[PTR_W-1:1]];
  assign rd_byte = rd_ptr[0] ? rd_word[RES_W-1:DATA_W] : rd_word[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      LCD_data <= '0;
    else
      LCD_data <= sel_sod ? rd_byte : cam_data;
  end

  assign pico_data = (rst_n && CS && direction) ? rd_byte : {DATA_W{1'bz}};

endmodule

// File: tb/tb_simd_top.sv
// Randomized and directed bench for simd_top against a lane-level arithmetic model.
// Build with or without +define+RESULT_SAT_EN; expectations follow the macro.
module tb_simd_top;

  logic       clk = 1'b0;
  logic       rst_n, CS, WR, RD, CD, excute, sel_poc, sel_sod, direction;
  logic [7:0] cam_data, host_val, LCD_data;
  logic       host_en;
  wire  [7:0] pico_data;

  always #5 clk = ~clk;

  assign pico_data = host_en ? host_val : 8'hzz;

  simd_top #(.LANES(32), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .WR(WR), .RD(RD), .CD(CD),
    .excute(excute), .sel_poc(sel_poc), .sel_sod(sel_sod),
    .direction(direction), .pico_data(pico_data), .cam_data(cam_data),
    .LCD_data(LCD_data)
  );

  // model state
  int   ma [32];
  int   mb [32];
  int   mr [32];
  int   maddr, mmode, mptr;
  bit   chk_en;
  int   total, bad;
  int   got [64];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_op(int m, int a, int b, int r);
    int s;
    case (m)
      0: s = (a + b) & 'hFFFF;
`ifdef RESULT_SAT_EN
      1: s = (a * b + r > 'hFFFF) ? 'hFFFF : a * b + r;
      2: s = a * b;
      default: s = (a < b) ? 0 : a - b;
`else
      1: s = (a * b + r) & 'hFFFF;
      2: s = a * b;
      default: s = (a - b) & 'hFFFF;
`endif
    endcase
    return s;
  endfunction

  function automatic int mbyte(int p);
    return (p % 2 == 1) ? (mr[p / 2] >> 8) & 'hFF : mr[p / 2] & 'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ma[i] = 0; mb[i] = 0; mr[i] = 0;
    end
    maddr = 0; mmode = 0; mptr = 0;
  endtask

  task automatic model_write(bit cd, int v);
    int d;
    if (cd) maddr = v & 127;
    else begin
      d = sel_poc ? int'(cam_data) : v;
      if (maddr < 32) begin
        ma[maddr] = d; maddr = (maddr + 1) % 32;
      end else if (maddr < 64) begin
        mb[maddr - 32] = d; maddr = 32 + ((maddr - 31) % 32);
      end else if (maddr == 64) mmode = d & 3;
    end
  endtask

  task automatic model_exec();
    for (int i = 0; i < 32; i++) mr[i] = ref_op(mmode, ma[i], mb[i], mr[i]);
    mptr = 0;
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  // Output check on every settled cycle
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (direction && CS && !host_en) chk("bus", int'(pico_data), mbyte(mptr));
      if (sel_sod) chk("lcd", int'(LCD_data), mbyte(mptr));
    end
  end

  task automatic bus_write(bit cs, bit cd, int v);
    chk_en = 0;
    @(negedge clk);
    CS = cs; CD = cd; direction = 0; host_en = 1; host_val = 8'(v); WR = 1;
    wait_clk(4);
    WR = 0;
    wait_clk(5);
    host_en = 0; CS = 1;
    if (cs) model_write(cd, v);
    $display("wr cs=%0d cd=%0d v=%02h poc=%0d cam=%02h", cs, cd, v, sel_poc, cam_data);
    chk_en = 1;
  endtask

  task automatic execute();
    chk_en = 0;
    @(negedge clk);
    excute = 1;
    wait_clk(4);
    excute = 0;
    wait_clk(5);
    model_exec();
    chk_en = 1;
  endtask

  task automatic wr_exec(int v);
    chk_en = 0;
    @(negedge clk);
    CS = 1; CD = 0; direction = 0; host_en = 1; host_val = 8'(v);
    WR = 1; excute = 1;
    wait_clk(4);
    WR = 0; excute = 0;
    wait_clk(5);
    host_en = 0;
    model_write(0, v);
    model_exec();
    $display("wr+exec v=%02h", v);
    chk_en = 1;
  endtask

  task automatic rd_pulse();
    chk_en = 0;
    @(negedge clk);
    CS = 1; RD = 1;
    wait_clk(4);
    RD = 0;
    wait_clk(5);
    mptr = (mptr + 1) % 64;
    chk_en = 1;
  endtask

  task automatic read_stream(string tag);
    chk_en = 0;
    host_en = 0; direction = 1; CS = 1;
    wait_clk(1);
    for (int k = 0; k < 64; k++) begin
      got[k] = int'(pico_data);
      chk("stream", got[k], mbyte(mptr));
      rd_pulse();
    end
    $display("read %s: %02h %02h %02h %02h %02h %02h", tag,
             got[0], got[1], got[2], got[3], got[4], got[5]);
  endtask

  task automatic set_mode(int m);
    bus_write(1, 1, 64);
    bus_write(1, 0, m);
  endtask

  initial begin
    total = 0; bad = 0; chk_en = 0;
    rst_n = 0; CS = 0; WR = 0; RD = 0; CD = 0; excute = 0;
    sel_poc = 0; sel_sod = 1; direction = 0; cam_data = 8'h00;
    host_en = 0; host_val = 8'h00;
    model_reset();
    wait_clk(3);
    chk("reset_lcd", int'(LCD_data), 0);
    rst_n = 1;
    wait_clk(2);
    chk_en = 1;
    read_stream("after reset");
    chk("reset_r0", got[0], 0);
    chk("reset_r63", got[63], 0);

    // deselected address write must leave addr_reg at 0
    bus_write(0, 1, 8'hFF);
    bus_write(1, 0, 8'h11);
    execute();
    read_stream("cs0 check");
    chk("cs0_addr_kept", got[0], 8'h11);

    // mode 0 directed
    set_mode(0);
    bus_write(1, 1, 0);
    bus_write(1, 0, 2); bus_write(1, 0, 3); bus_write(1, 0, 4);
    bus_write(1, 1, 32);
    bus_write(1, 0, 5); bus_write(1, 0, 6); bus_write(1, 0, 7);
    execute();
    read_stream("add");
    chk("add_b0", got[0], 8'h07);
    chk("add_b1", got[1], 8'h00);
    chk("add_b2", got[2], 8'h09);
    chk("add_b4", got[4], 8'h0B);
    chk("add_b6", got[6], 8'h00);
    chk("add_b63", got[63], 8'h00);
    chk_en = 0;
    direction = 0; host_en = 1; host_val = 8'h5A;
    wait_clk(1);
    chk("hiz", int'(pico_data), 8'h5A);
    host_en = 0;
    chk_en = 1;

    // multiply then accumulate
    set_mode(2);
    execute();
    read_stream("mul");
    chk("mul_r0", got[0], 10);
    chk("mul_r1", got[2], 18);
    chk("mul_r2", got[4], 28);
    set_mode(1);
    execute();
    read_stream("mac");
    chk("mac_r0", got[0], 20);
    chk("mac_r1", got[2], 36);
    chk("mac_r2", got[4], 56);

    // subtract: 2-5 and 3-6
    set_mode(3);
    execute();
    read_stream("sub");
`ifdef RESULT_SAT_EN
    chk("sub_lo", got[0], 8'h00);
    chk("sub_hi", got[1], 8'h00);
`else
    chk("sub_lo", got[0], 8'hFD);
    chk("sub_hi", got[1], 8'hFF);
`endif

    // FF*FF then 300 accumulations
    bus_write(1, 1, 0);  bus_write(1, 0, 8'hFF);
    bus_write(1, 1, 32); bus_write(1, 0, 8'hFF);
    set_mode(2);
    execute();
    read_stream("ffmul");
    chk("ff_lo", got[0], 8'h01);
    chk("ff_hi", got[1], 8'hFE);
    set_mode(1);
    for (int n = 0; n < 300; n++) execute();
    $display("exec x300 mode1");
    read_stream("ffmac");
`ifdef RESULT_SAT_EN
    chk("mac300_lo", got[0], 8'hFF);
    chk("mac300_hi", got[1], 8'hFF);
`else
    chk("mac300_lo", got[0], 8'h2D);
    chk("mac300_hi", got[1], 8'hA7);
`endif

    // auto-increment wrap in A and B; cam source; mode address does not step
    bus_write(1, 1, 30);
    bus_write(1, 0, 8'h21);
    sel_poc = 1; cam_data = 8'h22;
    bus_write(1, 0, 8'h99);
    sel_poc = 0;
    bus_write(1, 0, 8'h23); bus_write(1, 0, 8'h24);
    bus_write(1, 1, 62);
    bus_write(1, 0, 8'h31); bus_write(1, 0, 8'h32); bus_write(1, 0, 8'h33);
    bus_write(1, 1, 64);
    bus_write(1, 0, 3); bus_write(1, 0, 0);
    execute();
    read_stream("autoinc");
    chk("inc_a30", got[60], 8'h52);
    chk("inc_a31_cam", got[62], 8'h54);
    chk("inc_a0", got[0], 8'h56);
    chk("inc_a1", got[2], 8'h2A);

    // camera passthrough to the LCD
    chk_en = 0;
    sel_sod = 0; cam_data = 8'h3C;
    wait_clk(1);
    chk("cam_lcd0", int'(LCD_data), 8'h3C);
    cam_data = 8'hC3;
    wait_clk(1);
    chk("cam_lcd1", int'(LCD_data), 8'hC3);
    sel_sod = 1;
    wait_clk(2);
    chk_en = 1;

    // write coincident with execute uses the new operand
    bus_write(1, 1, 5);
    wr_exec(8'h40);
    read_stream("wr+exec");
    chk("coinc_r5", got[10], 8'h40);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      int op;
      op = $urandom_range(0, 9);
      sel_poc = 1'($urandom_range(0, 1));
      cam_data = 8'($urandom);
      if (op <= 5) bus_write(1, 0, int'($urandom_range(0, 255)));
      else if (op <= 7) bus_write(1, 1, int'($urandom_range(0, 70)));
      else if (op == 8) begin
        execute();
        $display("exec mode=%0d", mmode);
      end else bus_write(0, 0, int'($urandom_range(0, 255)));
      if (n % 20 == 19) begin
        sel_poc = 0;
        execute();
        read_stream("random");
      end
    end
    sel_poc = 0;

    // reset between execute and readback
    set_mode(0);
    bus_write(1, 1, 0);  bus_write(1, 0, 9);
    bus_write(1, 1, 32); bus_write(1, 0, 1);
    execute();
    chk("pre_rst_lcd", int'(LCD_data), 8'h0A);
    chk_en = 0;
    rst_n = 0;
    #1;
    chk("rst_lcd", int'(LCD_data), 0);
    model_reset();
    wait_clk(2);
    rst_n = 1;
    wait_clk(2);
    chk_en = 1;
    read_stream("after rst");
    chk("rst_r0", got[0], 0);
    bus_write(1, 1, 0);  bus_write(1, 0, 5);
    bus_write(1, 1, 32); bus_write(1, 0, 3);
    execute();
    read_stream("post rst add");
    chk("rst_mode_add", got[0], 8'h08);

    chk_en = 0;
    wait_clk(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_top.md
Name: simd_top

Overview:
- Byte-wide SIMD vector coprocessor slave on an 8080-style parallel bus driven by a Pico MCU.
- Host loads two 32-lane 8-bit operand banks (A, B) and a mode register. An execute pulse makes all lanes compute in parallel into a 16-bit result bank.
- Host reads results back byte-serially over the same bus.
- Also routes a camera byte stream (optional write source) and drives an LCD byte port.

Parameters:
- LANES, 32, lanes per bank; power of two, max 32; address map below is fixed for 32.
- DATA_W, 8, bus/operand width; results are 2*DATA_W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- CS  input  1  chip select, active-high; WR/RD ignored when 0
- WR  input  1  write strobe, active-high, asynchronous to clk
- RD  input  1  read strobe, active-high, asynchronous to clk
- CD  input  1  1 = address cycle, 0 = data cycle
- excute  input  1  execute request, rising edge starts compute
- sel_poc  input  1  data-write source: 0 = pico_data, 1 = cam_data
- sel_sod  input  1  LCD source: 1 = current read byte, 0 = cam_data passthrough
- direction  input  1  1 = block drives pico_data, 0 = host drives it
- pico_data  inout  8  bidirectional host bus
- cam_data  input  8  camera pixel byte
- LCD_data  output  8  LCD data byte

Behaviour:
- Strobe sync: WR, RD and excute each pass through a 2-FF synchronizer. Edge detect is on synchronized values. Actions occur 3 clks after the pin edge. Minimum strobe high/low time is 3 clks.
- Write, on WR rising edge with CS=1:
  - CD=1: addr_reg (7 bits) <= pico_data[6:0].
  - CD=0: data byte = sel_poc ? cam_data : pico_data, then decoded by addr_reg:
    - 0..31 -> A[addr].
    - 32..63 -> B[addr-32].
    - 64 -> mode <= byte[1:0].
    - 65..127 -> ignored.
  - After a CD=0 write to 0..63, addr_reg increments, wrapping 31->0 within A and 63->32 within B. addr_reg does not increment for addresses 64 and above.
- Modes, per lane i, unsigned, results 16 bits:
  - 0: R[i] = A[i] + B[i].
  - 1: R[i] = A[i]*B[i] + R[i] (accumulate onto previous result; 16-bit wrap).
  - 2: R[i] = A[i]*B[i].
  - 3: R[i] = A[i] - B[i] (two's complement, 16-bit).
- Execute: on synchronized excute rising edge, all lanes update in the same clk and read pointer rd_ptr <= 0. A WR edge coincident with execute is applied first, and the compute uses the new value.
- Read:
  - Byte stream order: R[0] low byte, R[0] high byte, R[1] low byte, ..., 64 bytes total.
  - rd_ptr is 6 bits. It advances on synchronized RD falling edge with CS=1 and wraps 63->0.
- Bus drive: pico_data = byte[rd_ptr] when direction=1 and CS=1, otherwise high-Z.
- LCD_data is registered: sel_sod ? byte[rd_ptr] : cam_data.
- Reset: A, B, R = 0; mode = 0; addr_reg = 0; rd_ptr = 0; LCD_data = 0; pico_data high-Z; synchronizers cleared.
- Reset mid-transfer aborts it. No partial write survives.

Optional Feature:
- Macro: RESULT_SAT_EN.
- Defined: mode 1 accumulate saturates at 16'hFFFF, and mode 3 clamps negative results to 0.
- Undefined: both wrap modulo 2^16 as specified above.

Test Plan:
- WR with CS=0, CD=1, pico_data=FF -> addr_reg unchanged (0); no bank written.
- Program mode=0 (addr 64), A[0..2]=2,3,4 (addr 0..2), B[0..2]=5,6,7 (addr 32..34), execute, 64 RD pulses with direction=1 -> stream 07 00 09 00 0B 00 then 00 for the rest; pico_data high-Z when direction=0.
- Same operands with mode=2, execute -> R[0..2] = 10, 18, 28. Then mode=1 without rewriting operands, execute -> R = 20, 36, 56.
- A[0]=B[0]=FF, mode=2 -> bytes 01 FE. Then mode=1 repeated 300 times -> wraps without RESULT_SAT_EN; holds FFFF with it.
- Auto-increment: address 30 then 4 data writes -> A[30], A[31], A[0], A[1] written. Also sel_poc=1 writes take cam_data, and sel_sod=0 makes LCD_data follow cam_data one clk later.
- Assert rst_n low between execute and reads -> all reads return 00, mode reads back as 0 behaviour (add), and LCD_data = 0 immediately.
